// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - round-robin two-master Wishbone arbiter for the shared line-memory port
// Optional slave-response watchdog: define WB_ARB_TIMEOUT_EN.
module wb_mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 128,
  parameter int SEL_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_dat_m,
  input  logic [SEL_W-1:0]  m0_sel,
  output logic [DATA_W-1:0] m0_dat_s,
  output logic              m0_ack,
  output logic              m0_rty,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_dat_m,
  input  logic [SEL_W-1:0]  m1_sel,
  output logic [DATA_W-1:0] m1_dat_s,
  output logic              m1_ack,
  output logic              m1_rty,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_adr,
  output logic [DATA_W-1:0] s_dat_m,
  output logic [SEL_W-1:0]  s_sel,
  input  logic [DATA_W-1:0] s_dat_s,
  input  logic              s_ack,
  input  logic              s_rty
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   req0, req1;
  logic   granted, gnt1, term, timeout_hit;

  assign req0    = m0_cyc & m0_stb;
  assign req1    = m1_cyc & m1_stb;
  assign granted = (state == GNT0) || (state == GNT1);
  assign gnt1    = (state == GNT1);
  assign term    = s_ack | s_rty;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of already-elapsed unanswered granted cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!granted)
      cnt <= '0;
    else if (!term)
      cnt <= cnt + 1'b1;
  end

  assign timeout_hit = granted && !term && (cnt == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_m   = '0;
    s_sel     = '0;
    m0_ack    = 1'b0;
    m0_rty    = 1'b0;
    m1_ack    = 1'b0;
    m1_rty    = 1'b0;
    m0_dat_s  = s_dat_s;
    m1_dat_s  = s_dat_s;

    case (state)
      IDLE: begin
        if (req0 && (!req1 || last))
          state_nxt = GNT0;
        else if (req1)
          state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        // An aborting master (cyc low) leaves the slave port fully idle
        if (gnt1 ? m1_cyc : m0_cyc) begin
          s_cyc   = 1'b1;
          s_stb   = gnt1 ? m1_stb   : m0_stb;
          s_we    = gnt1 ? m1_we    : m0_we;
          s_adr   = gnt1 ? m1_adr   : m0_adr;
          s_dat_m = gnt1 ? m1_dat_m : m0_dat_m;
          s_sel   = gnt1 ? m1_sel   : m0_sel;
        end
        if (timeout_hit) begin
          s_cyc = 1'b0;
          s_stb = 1'b0;
        end
        if (gnt1) begin
          m1_ack = s_ack;
          m1_rty = s_rty | timeout_hit;
        end else begin
          m0_ack = s_ack;
          m0_rty = s_rty | timeout_hit;
        end
        if (term || timeout_hit) begin
          state_nxt = IDLE;
          last_nxt  = gnt1;
        end else if (!(gnt1 ? m1_cyc : m0_cyc)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the single physical-memory port between the instruction-side cache (master 0) and the data-side write-back cache (master 1).
- It sits between the two cache `wb` master ports and the memory controller's slave port.
- It grants one master a full transaction: one 128-bit line read or write, terminated by slave ACK or RTY.
- It uses round-robin priority and has a one-cycle registered arbitration latency.

Parameters:
- ADDR_W, 12, line address width (byte address [15:4]).
- DATA_W, 128, line data width.
- SEL_W, 16, byte-select width (DATA_W/8).
- TIMEOUT, 255, slave-response watchdog limit in cycles; used only when WB_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle, strobe and write enable.
- m0_adr  in  ADDR_W  master 0 line address.
- m0_dat_m  in  DATA_W  master 0 write data.
- m0_sel  in  SEL_W  master 0 byte selects.
- m0_dat_s  out  DATA_W  read data to master 0.
- m0_ack, m0_rty  out  1 each  termination to master 0.
- m1_*  same set as m0_*, for master 1.
- s_cyc, s_stb, s_we  out  1 each  to memory slave.
- s_adr  out  ADDR_W.
- s_dat_m  out  DATA_W.
- s_sel  out  SEL_W.
- s_dat_s  in  DATA_W  slave read data.
- s_ack, s_rty  in  1 each  slave termination.

Behaviour:
- Request: reqN = mN_cyc & mN_stb.
- State register: IDLE, GNT0, GNT1. Priority register `last`: 1 bit, the master served most recently.
- Reset (async, immediate):
  - state=IDLE, last=1, so master 0 wins the first tie.
  - All outputs are 0: s_cyc, s_stb, s_we, s_adr, s_dat_m, s_sel, m*_ack, m*_rty.
- IDLE:
  - Slave outputs are all 0.
  - Only req0 → GNT0. Only req1 → GNT1.
  - Both requesting → grant the master != last.
  - Neither requesting → stay in IDLE.
  - Grant takes effect the cycle after the request is seen: one-cycle arbitration latency, zero wait if already granted.
- GNTn, slave path: s_cyc/s_stb/s_we/s_adr/s_dat_m/s_sel mirror master n combinationally.
- GNTn, return path:
  - mn_ack = s_ack and mn_rty = s_rty, combinationally.
  - The non-granted master's ack/rty are held at 0.
  - s_dat_s is broadcast to both m*_dat_s; masters qualify it with their own ack.
- Leaving GNTn:
  - s_ack or s_rty high → next state IDLE, last=n.
  - The grant is released after every termination, with no back-to-back hold by the same master. A master re-requesting immediately competes again in IDLE, guaranteeing alternation under continuous contention.
  - mn_cyc dropped before termination (abort) → slave outputs go 0 that cycle, next state IDLE, last unchanged.
  - s_ack and s_rty together → treat as ACK; forward both unchanged, and last=n.
- Masters are not required to hold requests stable while waiting. A request deasserted during its IDLE wait is simply not granted.
- The non-granted master's requests are ignored until the state returns to IDLE. There are no ack/rty pulses to the waiting master.
- Throughput: at most one transaction per two cycles per termination (terminate, IDLE, regrant); the slave is never driven with two masters.
- Mid-operation reset: outputs drop to 0 asynchronously. Any in-flight slave transaction is abandoned; the slave must tolerate CYC falling.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter clears on entry to GNTn and increments each granted cycle without s_ack/s_rty.
  - When the counter reaches TIMEOUT, in that cycle: mn_rty=1 for one cycle, s_cyc/s_stb are forced 0, next state IDLE, last=n.
  - The cache retries via its existing RTY handling.
- Undefined: no counter exists; a grant lasts until slave termination or master abort; the TIMEOUT parameter is ignored.

Test Plan:
- Reset: assert rst mid-GNT1 → all outputs 0 asynchronously. After release, req0 and req1 together → GNT0 first, one cycle later.
- Single master: req0 only, adr=12'h0A3, we=0; slave acks 3 cycles after grant with dat_s=128'hDEADBEEF… → m0_ack for 1 cycle with that data; m1_ack stays 0; IDLE next.
- Contention: both requesting continuously, slave acks each transaction after 2 cycles → grants alternate 0,1,0,1; s_adr matches the granted master every cycle.
- Write routing: m1 write, adr=12'h3FF, sel=16'hFFFF, dat_m=128'h1 → s_we=1 and s_dat_m=128'h1 for the whole grant; m0's pending request is granted only after m1_ack.
- Abort: m0 drops cyc 2 cycles into its grant while m1 is requesting → s_cyc is 0 that cycle; m1 is granted next, because last is unchanged and 0, so m1 has priority.
- Timeout (macro on, TIMEOUT=4): slave never responds to m0 → m0_rty pulses exactly at the 4th granted cycle; s_cyc drops; IDLE follows. With the macro off → the grant is held indefinitely.
